// File: rtl/rv_multicycle_core.sv
// Multi-cycle RV32I-subset core (add/sub/and/or/slt/addi/lw/sw/beq) with
// request/ready instruction and data ports, halt-on-illegal and cycle/retire counters.
module rv_multicycle_core #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_REGS   = 32,
  parameter int DEBUG_REG  = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  input  logic                  imem_ready,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  input  logic                  dmem_ready,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  cycle_cnt,
  output logic [CNT_WIDTH-1:0]  instret_cnt,
  output logic [15:0]           debug
);

  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [RW-1:0] DBG_IDX = RW'(DEBUG_REG);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [2:0] {
    S_START, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] pc;
  logic [31:0]           ir;
  logic [DATA_WIDTH-1:0] a_reg, b_reg, imm_reg, alu_out, mdr;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [RW-1:0]         rd, rs1, rs2;
  logic                  is_r, is_i, is_ld, is_st, is_br, legal;
  logic [DATA_WIDTH-1:0] rs1_val, rs2_val, imm_d, alu_res, wb_data;
  logic                  retire;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign rd     = ir[7 +: RW];
  assign rs1    = ir[15 +: RW];
  assign rs2    = ir[20 +: RW];

  assign is_r  = (opcode == OP_R);
  assign is_i  = (opcode == OP_I);
  assign is_ld = (opcode == OP_LD);
  assign is_st = (opcode == OP_ST);
  assign is_br = (opcode == OP_BR);
  assign legal = is_r | is_i | is_ld | is_st | is_br;

  assign rs1_val = (rs1 == '0) ? '0 : regs[rs1];
  assign rs2_val = (rs2 == '0) ? '0 : regs[rs2];

  // Immediate formats, sign-extended to the datapath width.
  always_comb begin
    imm_d = DATA_WIDTH'($signed(ir[31:20]));
    if (is_st)
      imm_d = DATA_WIDTH'($signed({ir[31:25], ir[11:7]}));
    else if (is_br)
      imm_d = DATA_WIDTH'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
  end

  always_comb begin
    alu_res = a_reg + imm_reg;
    if (is_r) begin
      case (funct3)
        3'b000:  alu_res = ir[30] ? (a_reg - b_reg) : (a_reg + b_reg);
        3'b111:  alu_res = a_reg & b_reg;
        3'b110:  alu_res = a_reg | b_reg;
        3'b010: begin
          alu_res    = '0;
          alu_res[0] = $signed(a_reg) < $signed(b_reg);
        end
        default: alu_res = a_reg + b_reg;
      endcase
    end
  end

  assign wb_data = is_ld ? mdr : alu_out;
  assign retire  = (state == S_EXEC && is_br) ||
                   (state == S_MEM && dmem_ready && is_st) ||
                   (state == S_WB);

  always_ff @(posedge clk) begin
    if (rst) state <= S_START;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    halted   = 1'b0;
    case (state)
      S_START:  state_nx = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_nx = S_DECODE;
      end
      S_DECODE: state_nx = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_br)               state_nx = S_FETCH;
        else if (is_ld || is_st) state_nx = S_MEM;
        else                     state_nx = S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_st;
        if (dmem_ready) state_nx = is_st ? S_FETCH : S_WB;
      end
      S_WB:     state_nx = S_FETCH;
      S_HALT:   halted   = 1'b1;
      default:  state_nx = S_START;
    endcase
  end

  assign imem_addr  = pc;
  assign dmem_addr  = alu_out[ADDR_WIDTH-1:0];
  assign dmem_wdata = b_reg;
  assign debug      = regs[DBG_IDX][15:0];

  // Datapath registers only move in the state that owns them, so
  // address/data outputs stay stable across memory wait states.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      imm_reg <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (imem_ready) ir <= imem_rdata;
        S_DECODE: begin
          a_reg   <= rs1_val;
          b_reg   <= rs2_val;
          imm_reg <= imm_d;
        end
        S_EXEC: begin
          alu_out <= alu_res;
          if (is_br && a_reg == b_reg) pc <= pc + imm_reg[ADDR_WIDTH-1:0];
          else                         pc <= pc + ADDR_WIDTH'(4);
        end
        S_MEM: if (dmem_ready && is_ld) mdr <= dmem_rdata;
        S_WB:  if (rd != '0) regs[rd] <= wb_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      if (retire) instret_cnt <= instret_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_rv_multicycle_core.sv
// Bench for rv_multicycle_core: directed and random programs against an
// instruction-level reference model, with a scoreboarded memory-port monitor.
module tb_rv_multicycle_core;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req, imem_ready = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic          dmem_req, dmem_we, dmem_ready = 1'b0;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata = '0;
  logic          halted;
  logic [CW-1:0] cycle_cnt, instret_cnt;
  logic [15:0]   debug;

  rv_multicycle_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(32),
                       .DEBUG_REG(1), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .halted(halted), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .debug(debug)
  );

  always #5 clk = ~clk;

  typedef enum int {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_ADDI, K_LW, K_SW, K_BEQ, K_ILL} kind_e;
  typedef struct { kind_e k; int rd; int rs1; int rs2; int imm; } ins_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } dtx_t;

  ins_t          prog [256];
  logic [31:0]   imem [256];
  logic [DW-1:0] dmem_rt [int];
  logic [AW-1:0] exp_fetch [$];
  dtx_t          exp_dtx [$];
  int            fetch_entry [$];
  int            dmem_wseq [$];
  int            imem_wmax = 0, dmem_wmax = 0;
  int            n_cmp = 0, n_err = 0;
  int            tb_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_line(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected transfer (t=%0t)", nm, $time);
  endtask

  function automatic ins_t mk(input kind_e k, input int rd, input int rs1, input int rs2, input int imm);
    ins_t t;
    t.k = k; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm;
    return t;
  endfunction

  function automatic logic [DW-1:0] minit(input logic [AW-1:0] a);
    return {a, ~a};
  endfunction

  function automatic logic [31:0] enc(input ins_t t);
    logic [31:0] im;
    logic [4:0]  d, s1, s2;
    im = t.imm; d = 5'(t.rd); s1 = 5'(t.rs1); s2 = 5'(t.rs2);
    case (t.k)
      K_ADD:  return {7'h00, s2, s1, 3'b000, d, 7'h33};
      K_SUB:  return {7'h20, s2, s1, 3'b000, d, 7'h33};
      K_AND:  return {7'h00, s2, s1, 3'b111, d, 7'h33};
      K_OR:   return {7'h00, s2, s1, 3'b110, d, 7'h33};
      K_SLT:  return {7'h00, s2, s1, 3'b010, d, 7'h33};
      K_ADDI: return {im[11:0], s1, 3'b000, d, 7'h13};
      K_LW:   return {im[11:0], s1, 3'b010, d, 7'h03};
      K_SW:   return {im[11:5], s2, s1, 3'b010, im[4:0], 7'h23};
      K_BEQ:  return {im[12], im[10:5], s2, s1, 3'b000, im[4:1], im[11], 7'h63};
      default: return {im[24:0], 7'h7F};
    endcase
  endfunction

  // Reference model: executes the program architecturally and queues every
  // expected fetch address and data transfer in program order.
  task automatic iss(output int ret, output logic [15:0] dbg);
    logic [DW-1:0] x [32];
    logic [DW-1:0] dref [int];
    logic [AW-1:0] pc, ea;
    logic [DW-1:0] v;
    ins_t          in;
    bit            wr;
    foreach (x[i]) x[i] = '0;
    pc = '0; ret = 0;
    for (int s = 0; s < 1000; s++) begin
      in = prog[pc[9:2]];
      exp_fetch.push_back(pc);
      if (in.k == K_ILL) break;
      wr = 1'b1; v = '0;
      case (in.k)
        K_ADD:  v = x[in.rs1] + x[in.rs2];
        K_SUB:  v = x[in.rs1] - x[in.rs2];
        K_AND:  v = x[in.rs1] & x[in.rs2];
        K_OR:   v = x[in.rs1] | x[in.rs2];
        K_SLT:  v = ($signed(x[in.rs1]) < $signed(x[in.rs2])) ? DW'(1) : '0;
        K_ADDI: v = x[in.rs1] + DW'(in.imm);
        K_LW: begin
          ea = AW'(x[in.rs1] + DW'(in.imm));
          exp_dtx.push_back('{1'b0, ea, '0});
          v = dref.exists(int'(ea)) ? dref[int'(ea)] : minit(ea);
        end
        K_SW: begin
          ea = AW'(x[in.rs1] + DW'(in.imm));
          exp_dtx.push_back('{1'b1, ea, x[in.rs2]});
          dref[int'(ea)] = x[in.rs2];
          wr = 1'b0;
        end
        default: wr = 1'b0;
      endcase
      pc = (in.k == K_BEQ && x[in.rs1] == x[in.rs2]) ? pc + AW'(in.imm) : pc + AW'(4);
      if (wr && in.rd != 0) x[in.rd] = v;
      ret++;
    end
    dbg = x[1][15:0];
  endtask

  always @(posedge clk) tb_cyc <= rst ? 0 : tb_cyc + 1;

  // Memory responders: random wait states, random ready while idle.
  bit i_act = 0, d_act = 0;
  int icnt = 0, iw = 0, dcnt = 0, dw = 0;
  always @(negedge clk) begin
    if (imem_req) begin
      if (!i_act) begin i_act = 1; icnt = 0; iw = $urandom_range(imem_wmax, 0); end
      if (icnt >= iw) begin imem_ready = 1'b1; imem_rdata = imem[imem_addr[9:2]]; end
      else begin imem_ready = 1'b0; icnt++; end
    end else begin
      i_act = 0; imem_ready = 1'($urandom_range(1, 0)); imem_rdata = $urandom;
    end
    if (dmem_req) begin
      if (!d_act) begin
        d_act = 1; dcnt = 0;
        dw = (dmem_wseq.size() > 0) ? dmem_wseq.pop_front() : $urandom_range(dmem_wmax, 0);
      end
      if (dcnt >= dw) begin
        dmem_ready = 1'b1;
        if (dmem_we) dmem_rt[int'(dmem_addr)] = dmem_wdata;
        else dmem_rdata = dmem_rt.exists(int'(dmem_addr)) ? dmem_rt[int'(dmem_addr)] : minit(dmem_addr);
      end else begin dmem_ready = 1'b0; dcnt++; end
    end else begin
      d_act = 0; dmem_ready = 1'($urandom_range(1, 0)); dmem_rdata = $urandom;
    end
  end

  // Monitor: scoreboard pops on every completed transfer, plus hold checks.
  logic          prev_ireq = 0, hold_i = 0, hold_d = 0;
  logic [AW-1:0] hold_ia;
  dtx_t          hold_dt, mon_e;
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (imem_req && !prev_ireq) fetch_entry.push_back(tb_cyc);
      if (hold_i && imem_req) chk("imem_addr_stable", imem_addr, hold_ia);
      if (hold_d && dmem_req) begin
        chk("dmem_we_stable", dmem_we, hold_dt.we);
        chk("dmem_addr_stable", dmem_addr, hold_dt.addr);
        chk("dmem_wdata_stable", dmem_wdata, hold_dt.wdata);
      end
      if (imem_req && imem_ready) begin
        if (exp_fetch.size() == 0) fail_line("fetch_extra");
        else chk("fetch_addr", imem_addr, exp_fetch.pop_front());
      end
      if (dmem_req && dmem_ready) begin
        if (exp_dtx.size() == 0) fail_line("dmem_extra");
        else begin
          mon_e = exp_dtx.pop_front();
          chk("dmem_we", dmem_we, mon_e.we);
          chk("dmem_addr", dmem_addr, mon_e.addr);
          if (mon_e.we) chk("dmem_wdata", dmem_wdata, mon_e.wdata);
        end
      end
    end
    hold_i = !rst && imem_req && !imem_ready; hold_ia = imem_addr;
    hold_d = !rst && dmem_req && !dmem_ready; hold_dt = '{dmem_we, dmem_addr, dmem_wdata};
    prev_ireq = imem_req;
  end

  task automatic clear_prog();
    foreach (prog[i]) prog[i] = mk(K_ILL, 0, 0, 0, 0);
  endtask

  task automatic start_prog(output int ret, output logic [15:0] dbg);
    foreach (prog[i]) imem[i] = enc(prog[i]);
    @(negedge clk); #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_imem_req", imem_req, 0);     chk("rst_imem_addr", imem_addr, 0);
    chk("rst_dmem_req", dmem_req, 0);     chk("rst_dmem_we", dmem_we, 0);
    chk("rst_dmem_addr", dmem_addr, 0);   chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_halted", halted, 0);         chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_instret", instret_cnt, 0);   chk("rst_debug", debug, 0);
    exp_fetch.delete(); exp_dtx.delete(); fetch_entry.delete(); dmem_rt.delete();
    iss(ret, dbg);
    rst = 1'b0;
    #1 chk("cyc1_imem_req", imem_req, 0);
    @(negedge clk); #2;
    chk("cyc2_imem_req", imem_req, 1);
    chk("cyc2_imem_addr", imem_addr, 0);
  endtask

  task automatic finish_prog(input int budget, input int ret, input logic [15:0] dbg);
    int c = 0;
    while (!halted && c < budget) begin @(negedge clk); #2; c++; end
    chk("halt_reached", halted, 1);
    chk("fetch_q_left", exp_fetch.size(), 0);
    chk("dmem_q_left", exp_dtx.size(), 0);
    chk("instret_cnt", instret_cnt, ret);
    chk("debug", debug, dbg);
    chk("cycle_cnt", cycle_cnt, tb_cyc);
  endtask

  task automatic chk_lat(input string nm, input int idx, input int exp);
    if (fetch_entry.size() > idx + 1) chk(nm, fetch_entry[idx+1] - fetch_entry[idx], exp);
    else fail_line({nm, "_missing_fetch"});
  endtask

  initial begin
    int ret, c, ic, cc;
    logic [15:0] dbg;

    // ALU program
    clear_prog();
    prog[0] = mk(K_ADDI, 1, 0, 0, 5);
    prog[1] = mk(K_ADDI, 2, 0, 0, -3);
    prog[2] = mk(K_ADD,  1, 1, 2, 0);
    prog[3] = mk(K_SUB,  3, 2, 1, 0);
    prog[4] = mk(K_SLT,  4, 2, 1, 0);
    prog[5] = mk(K_SW,   0, 0, 3, 'h40);
    prog[6] = mk(K_SW,   0, 0, 4, 'h44);
    start_prog(ret, dbg);
    finish_prog(200, ret, dbg);
    chk("alu_debug", debug, 16'h0002);
    for (int i = 0; i < 5; i++) chk_lat("lat_alu", i, 4);

    // Store with 3 wait states, then load back
    clear_prog();
    prog[0] = mk(K_ADDI, 1, 0, 0, 2);
    prog[1] = mk(K_SW,   0, 0, 1, 'h100);
    prog[2] = mk(K_LW,   5, 0, 0, 'h100);
    prog[3] = mk(K_SW,   0, 0, 5, 'h104);
    dmem_wseq = '{3, 0, 0};
    start_prog(ret, dbg);
    finish_prog(200, ret, dbg);
    chk_lat("lat_sw_wait", 1, 7);
    chk_lat("lat_lw", 2, 5);

    // Branches: forward taken, backward taken, not taken
    clear_prog();
    prog[0] = mk(K_ADDI, 1, 0, 0, 1);
    prog[1] = mk(K_BEQ,  0, 0, 0, 28);
    prog[8] = mk(K_BEQ,  0, 0, 0, -8);
    prog[6] = mk(K_BEQ,  0, 1, 0, 8);
    start_prog(ret, dbg);
    finish_prog(200, ret, dbg);
    for (int i = 1; i < 4; i++) chk_lat("lat_beq", i, 3);

    // x0 write dropped; illegal opcode halts, counters behave
    clear_prog();
    prog[0] = mk(K_ADDI, 0, 0, 0, 7);
    prog[1] = mk(K_SW,   0, 0, 0, 'h10);
    start_prog(ret, dbg);
    finish_prog(200, ret, dbg);
    ic = instret_cnt; cc = cycle_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      chk("halt_no_req", {imem_req, dmem_req}, 0);
    end
    chk("halt_instret_frozen", instret_cnt, ic);
    chk("halt_cycle_runs", cycle_cnt, cc + 10);

    // Reset in the middle of a stalled store
    clear_prog();
    prog[0] = mk(K_ADDI, 1, 0, 0, 9);
    prog[1] = mk(K_SW,   0, 0, 1, 'h100);
    dmem_wseq = '{20};
    start_prog(ret, dbg);
    c = 0;
    while (!dmem_req && c < 50) begin @(negedge clk); #2; c++; end
    chk("midmem_reached", dmem_req, 1);
    @(negedge clk); #2;
    rst = 1'b1;
    @(negedge clk); #2;
    chk("midmem_dmem_req", dmem_req, 0);
    chk("midmem_pc", imem_addr, 0);
    chk("midmem_cycle_cnt", cycle_cnt, 0);
    chk("midmem_instret", instret_cnt, 0);
    dmem_wseq.delete();
    start_prog(ret, dbg);
    finish_prog(200, ret, dbg);

    // Random programs with random wait states
    imem_wmax = 3; dmem_wmax = 3;
    for (int p = 0; p < 6; p++) begin
      clear_prog();
      for (int i = 0; i < 40; i++) begin
        ins_t t;
        int r, k;
        r = $urandom_range(9, 0);
        t = mk(K_ADDI, $urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(7, 0),
               int'($urandom_range(4095, 0)) - 2048);
        if (i >= 4) begin
          case (r)
            0: t.k = K_ADD;  1: t.k = K_SUB;  2: t.k = K_AND;  3: t.k = K_OR;
            4: t.k = K_SLT;  7: t.k = K_LW;   8: t.k = K_SW;   9: t.k = K_BEQ;
            default: t.k = K_ADDI;
          endcase
        end
        if (t.k == K_BEQ) begin
          k = $urandom_range(3, 1);
          if (i + k > 40) k = 40 - i;
          t.imm = 4 * k;
        end
        prog[i] = t;
      end
      start_prog(ret, dbg);
      finish_prog(3000, ret, dbg);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
